// File: rtl/uart_tx_param_if.sv
// Host-side bundle for uart_tx_param: word handshake, per-frame line config and serial/status outputs.
// master drives words and config; slave is the transmitter.
interface uart_tx_param_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
);
  logic [DIV_W-1:0]  baud_div;
  logic [1:0]        parity_mode;
  logic              stop2;
  logic              msb_first;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              ser_out;
  logic              busy;
  logic              status;

  modport master (
    output baud_div, parity_mode, stop2, msb_first, tx_valid, tx_data,
    input  tx_ready, ser_out, busy, status
  );

  modport slave (
    input  baud_div, parity_mode, stop2, msb_first, tx_valid, tx_data,
    output tx_ready, ser_out, busy, status
  );
endinterface

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-word holding register; line goes low one cycle after accept when idle.
// Backpressure: tx_ready drops while the holding register is full; frames run back-to-back when a word is waiting.
module uart_tx_param #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic            clk_in,
  input  logic            reset,
  uart_tx_param_if.slave  u_if
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_hold, r_shift;
  logic              r_hold_full;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DIV_W-1:0]  r_baud_cnt, r_div;
  logic              r_par_en, r_par_bit, r_stop2, r_msb;
  logic              r_ser, r_busy, r_idle;

  logic w_bit_end, w_head, w_accept;
  logic w_ser_nxt, w_busy_nxt, w_load, w_shift, w_bit_inc, w_bit_clr, w_frame_end;

  assign w_bit_end = (r_baud_cnt == r_div);
  assign w_head    = r_msb ? r_shift[DATA_W-1] : r_shift[0];
  assign w_accept  = u_if.tx_valid && !r_hold_full;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ser_nxt   = r_ser;
    w_busy_nxt  = r_busy;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_bit_inc   = 1'b0;
    w_bit_clr   = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ser_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
        if (r_hold_full) begin
          w_state_nxt = S_START;
          w_ser_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      S_START: if (w_bit_end) begin
        w_state_nxt = S_DATA;
        w_ser_nxt   = w_head;
        w_shift     = 1'b1;
        w_bit_clr   = 1'b1;
      end
      S_DATA: if (w_bit_end) begin
        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
          w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
          w_ser_nxt   = r_par_en ? r_par_bit : 1'b1;
        end else begin
          w_ser_nxt = w_head;
          w_shift   = 1'b1;
          w_bit_inc = 1'b1;
        end
      end
      S_PARITY: if (w_bit_end) begin
        w_state_nxt = S_STOP1;
        w_ser_nxt   = 1'b1;
      end
      S_STOP1: if (w_bit_end) begin
        if (r_stop2) w_state_nxt = S_STOP2;
        else         w_frame_end = 1'b1;
      end
      S_STOP2: if (w_bit_end) w_frame_end = 1'b1;
      default: begin
        w_state_nxt = S_IDLE;
        w_ser_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
    // A waiting word chains straight into the next start bit.
    if (w_frame_end) begin
      if (r_hold_full) begin
        w_state_nxt = S_START;
        w_ser_nxt   = 1'b0;
        w_load      = 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
        w_ser_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_baud_cnt  <= '0;
      r_div       <= '0;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop2     <= 1'b0;
      r_msb       <= 1'b0;
      r_ser       <= 1'b1;
      r_busy      <= 1'b0;
      r_idle      <= 1'b1;
    end else begin
      r_ser  <= w_ser_nxt;
      r_busy <= w_busy_nxt;
      r_idle <= !w_busy_nxt;

      if (w_accept) begin
        r_hold      <= u_if.tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      if (r_state == S_IDLE || w_bit_end) r_baud_cnt <= '0;
      else                                r_baud_cnt <= r_baud_cnt + DIV_W'(1);

      if (w_load || w_bit_clr) r_bit_cnt <= '0;
      else if (w_bit_inc)      r_bit_cnt <= r_bit_cnt + CNT_W'(1);

      if (w_load)       r_shift <= r_hold;
      else if (w_shift) r_shift <= r_msb ? {r_shift[DATA_W-2:0], 1'b0}
                                         : {1'b0, r_shift[DATA_W-1:1]};

      // Line config is frozen for the whole frame at the load edge.
      if (w_load) begin
        r_div     <= u_if.baud_div;
        r_par_en  <= ^u_if.parity_mode;
        r_par_bit <= (^r_hold) ^ (u_if.parity_mode == 2'b10);
        r_stop2   <= u_if.stop2;
        r_msb     <= u_if.msb_first;
      end
    end
  end

  assign u_if.tx_ready = !r_hold_full;
  assign u_if.ser_out  = r_ser;
  assign u_if.busy     = r_busy;
  assign u_if.status   = r_idle;
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, giving the data bits per frame, legal range 5..9.
REQ-002 The block SHALL take parameter DIV_W, default 16, giving the width of the baud divisor.
REQ-003 clk_in  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; assertion SHALL act immediately and release SHALL be sampled on clk_in.
REQ-005 baud_div  input  DIV_W  bit period minus one, in clk_in cycles.
REQ-006 parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-007 stop2  input  1  0 gives one stop bit, 1 gives two stop bits.
REQ-008 msb_first  input  1  0 sends data LSB first, 1 sends data MSB first.
REQ-009 tx_valid  input  1  tx_data is offered this cycle.
REQ-010 tx_data  input  DATA_W  word to transmit.
REQ-011 tx_ready  output  1  holding register empty; the block can accept a word.
REQ-012 ser_out  output  1  serial line; idles high.
REQ-013 busy  output  1  a frame is in progress.
REQ-014 status  output  1  idle indicator, equal to NOT busy.

Function
REQ-015 A word SHALL be accepted on a rising edge where tx_valid and tx_ready are both 1, and SHALL be stored in a one-entry holding register.
REQ-016 tx_ready SHALL equal NOT hold_full; holding-register state SHALL NOT depend combinationally on tx_valid.
REQ-017 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP1 and STOP2; all outputs SHALL be registered.
REQ-018 From IDLE with hold_full=1, the next edge SHALL enter START with ser_out=0 and busy=1, move the holding register into the shift register and clear hold_full.
REQ-019 A word accepted at edge k into an idle block SHALL drive ser_out low from edge k+1.
REQ-020 At frame start, baud_div, parity_mode, stop2 and msb_first SHALL be latched; input changes mid-frame SHALL have no effect on that frame.
REQ-021 The bit counter SHALL restart at frame start, and every bit including the start bit SHALL last exactly baud_div+1 clk_in cycles.
REQ-022 baud_div=0 SHALL give one clock cycle per bit.
REQ-023 DATA SHALL send DATA_W bits in the order selected by msb_first.
REQ-024 PARITY SHALL occur only when parity_mode is 01 or 10.
REQ-025 The even-parity bit SHALL be the XOR of the data bits; the odd-parity bit SHALL be its inverse.
REQ-026 STOP1 SHALL drive ser_out=1, and STOP2 SHALL follow it only when the latched stop2 is 1.
REQ-027 At the end of the last stop bit with hold_full=1, the FSM SHALL go directly to START with no idle cycle (back-to-back frames).
REQ-028 At the end of the last stop bit with hold_full=0, the FSM SHALL go to IDLE with busy=0.
REQ-029 A word SHALL be acceptable during any state, including the final stop-bit cycle; a simultaneous accept and frame-start transfer cannot occur because tx_ready=0 whenever hold_full=1.
REQ-030 Illegal FSM encodings SHALL recover to IDLE on the next edge with ser_out=1.

Reset
REQ-031 While reset=0, the outputs SHALL be ser_out=1, busy=0, status=1 and tx_ready=1.
REQ-032 While reset=0, the internal state SHALL be FSM=IDLE, hold_full=0, and the bit and baud counters cleared.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, drive ser_out=1 and discard any held word.
REQ-034 After reset release, no frame SHALL start until a new word is accepted.

Verification
REQ-035 Basic frame: DATA_W=8, baud_div=3, parity none, stop2=0, LSB first, send 0xA5 -> ser_out sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, 40 cycles total, then busy=0.
REQ-036 Parity and ordering: 0xA5 with even parity -> parity bit 0; with odd parity -> parity bit 1; with msb_first=1 -> data bits 1,0,1,0,0,1,0,1; with stop2=1 -> the stop-high period is 8 cycles for baud_div=3.
REQ-037 Back-to-back: 0x01 accepted while idle, then 0xFF offered continuously -> 0xFF accepted one cycle after the first frame starts; tx_ready=0 until the second frame starts; the second start bit immediately follows the first stop bit with no gap.
REQ-038 Config latching: change baud_div from 3 to 7 during the data bits of a frame -> the current frame keeps 4-cycle bits and the next frame uses 8-cycle bits.
REQ-039 Reset mid-frame: assert reset during data bit 3 -> ser_out=1, busy=0 and tx_ready=1 within the same cycle; after release, ser_out stays 1 with no spurious frame.
REQ-040 Minimum divisor: baud_div=0, send 0x3C with odd parity -> 11 consecutive one-cycle bits 0,0,0,1,1,1,1,0,0,1,1.
